// File: rtl/alu_multicycle_ctrl.sv
// ALU control and execution unit: decodes ALUOp/funct, runs single-cycle ops
// directly and MULTU/DIVU as WIDTH-step iterations into HI/LO, with valid/ready on both sides.
module alu_multicycle_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err,
  output logic             busy
);

  localparam int unsigned CNTW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT,
    OP_MULTU, OP_DIVU, OP_MFHI, OP_MFLO, OP_ILL
  } op_t;

  state_t           state, state_nxt;
  op_t              op;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] opnd;          // multiplicand (MUL) or divisor (DIV)
  logic [WIDTH-1:0] w_hi, w_lo;    // partial product / remainder : multiplier / quotient
  logic [CNTW-1:0]  cnt;
  logic             accept;
  logic [WIDTH-1:0] sc_result;
  logic             sc_err;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] it_hi, it_lo;

  always_comb begin
    op = OP_ILL;
    case (alu_op)
      3'b000: begin
        case (func)
          6'b100000: op = OP_ADD;
          6'b100010: op = OP_SUB;
          6'b100100: op = OP_AND;
          6'b100101: op = OP_OR;
          6'b100111: op = OP_NOR;
          6'b101010: op = OP_SLT;
          6'b011001: op = OP_MULTU;
          6'b011011: op = OP_DIVU;
          6'b010000: op = OP_MFHI;
          6'b010010: op = OP_MFLO;
          default:   op = OP_ILL;
        endcase
      end
      3'b001:  op = OP_ADD;
      3'b010:  op = OP_SUB;
      3'b011:  op = OP_OR;
      default: op = OP_ILL;
    endcase
  end

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == MUL) || (state == DIV);
  assign zero     = (result == '0);

  always_comb begin
    sc_result = '0;
    sc_err    = 1'b0;
    case (op)
      OP_ADD:  sc_result = a + b;
      OP_SUB:  sc_result = a - b;
      OP_AND:  sc_result = a & b;
      OP_OR:   sc_result = a | b;
      OP_NOR:  sc_result = ~(a | b);
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_MFHI: sc_result = hi;
      OP_MFLO: sc_result = lo;
      OP_ILL:  sc_err    = 1'b1;
      default: sc_result = '0;
    endcase
  end

  // One iteration step: shift-add multiply or restoring divide on {w_hi,w_lo}.
  // The subtraction is done in WIDTH bits since a successful remainder is always < divisor.
  always_comb begin
    mul_sum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {w_hi, w_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    if (state == DIV) begin
      it_hi = div_ge ? (div_shift[WIDTH-1:0] - opnd) : div_shift[WIDTH-1:0];
      it_lo = {w_lo[WIDTH-2:0], div_ge};
    end else begin
      it_hi = mul_sum[WIDTH:1];
      it_lo = {mul_sum[0], w_lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && op == OP_MULTU)             state_nxt = MUL;
        else if (accept && op == OP_DIVU && b != '0) state_nxt = DIV;
      end
      MUL, DIV: if (cnt == '0) state_nxt = DONE;
      DONE:     if (out_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      hi        <= '0;
      lo        <= '0;
      opnd      <= '0;
      w_hi      <= '0;
      w_lo      <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (op == OP_MULTU) begin
              opnd      <= a;
              w_hi      <= '0;
              w_lo      <= b;
              cnt       <= CNTW'(WIDTH - 1);
              out_valid <= 1'b0;
            end else if (op == OP_DIVU && b != '0) begin
              opnd      <= b;
              w_hi      <= '0;
              w_lo      <= a;
              cnt       <= CNTW'(WIDTH - 1);
              out_valid <= 1'b0;
            end else if (op == OP_DIVU) begin
              hi        <= a;
              lo        <= '1;
              result    <= '1;
              err       <= 1'b1;
              out_valid <= 1'b1;
            end else begin
              result    <= sc_result;
              err       <= sc_err;
              out_valid <= 1'b1;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        MUL, DIV: begin
          w_hi <= it_hi;
          w_lo <= it_lo;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            hi        <= it_hi;
            lo        <= it_lo;
            result    <= it_lo;
            err       <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle_ctrl.sv
// Directed bench for alu_multicycle_ctrl (WIDTH=32) with hand-computed expectations.
module tb_alu_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  alu_op = '0;
  logic [5:0]  func = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        err;
  logic        busy;

  int passed = 0;
  int total  = 0;

  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_SLT = 6'b101010,
                         F_MULTU = 6'b011001, F_DIVU = 6'b011011,
                         F_MFHI = 6'b010000, F_MFLO = 6'b010010;

  alu_multicycle_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .func(func), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [2:0] op, input logic [5:0] fn, input logic [31:0] x, input logic [31:0] y);
    int w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_wait", in_ready, 1'b1);
    in_valid = 1'b1; alu_op = op; func = fn; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int n = 1;
    int nb = 0;
    while (!out_valid && n < 200) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_busy_cycles"}, nb, exp_lat - 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_zero", zero, 1'b1);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);

    // T1: SUB 5-7
    send(3'b000, F_SUB, 32'd5, 32'd7);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_result", result, 32'hFFFF_FFFE);
    chk("t1_zero", zero, 1'b0);
    chk("t1_err", err, 1'b0);

    // T2: signed SLT, then alu_op SUB giving zero
    send(3'b000, F_SLT, 32'hFFFF_FFFF, 32'd1);
    chk("t2_slt", result, 32'd1);
    send(3'b000, F_SLT, 32'd1, 32'hFFFF_FFFF);
    chk("t2_slt_rev", result, 32'd0);
    send(3'b010, 6'b000000, 32'd9, 32'd9);
    chk("t2_sub_result", result, 32'd0);
    chk("t2_sub_zero", zero, 1'b1);
    send(3'b001, 6'b111111, 32'hFFFF_FFFF, 32'd2);
    chk("t2_add_wrap", result, 32'd1);

    // T3: MULTU 2^16 * 2^16
    send(3'b000, F_MULTU, 32'h0001_0000, 32'h0001_0000);
    chk("t3_busy", busy, 1'b1);
    chk("t3_in_ready", in_ready, 1'b0);
    wait_done("t3_mul", 33);
    chk("t3_result", result, 32'h0);
    send(3'b000, F_MFHI, 32'h0, 32'h0);
    chk("t3_mfhi", result, 32'd1);
    send(3'b000, F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("t3_mul_max", 33);
    chk("t3_max_lo", result, 32'd1);
    send(3'b000, F_MFHI, 32'h0, 32'h0);
    chk("t3_max_hi", result, 32'hFFFF_FFFE);

    // T4: DIVU 100/7, then divide by zero
    send(3'b000, F_DIVU, 32'd100, 32'd7);
    wait_done("t4_div", 33);
    chk("t4_quot", result, 32'd14);
    chk("t4_err", err, 1'b0);
    send(3'b000, F_MFHI, 32'h0, 32'h0);
    chk("t4_rem", result, 32'd2);
    send(3'b000, F_DIVU, 32'hFFFF_FFFF, 32'd16);
    wait_done("t4_div_big", 33);
    chk("t4_big_quot", result, 32'h0FFF_FFFF);
    send(3'b000, F_MFHI, 32'h0, 32'h0);
    chk("t4_big_rem", result, 32'd15);
    send(3'b000, F_DIVU, 32'd100, 32'd0);
    chk("t4_dz_valid", out_valid, 1'b1);
    chk("t4_dz_result", result, 32'hFFFF_FFFF);
    chk("t4_dz_err", err, 1'b1);
    chk("t4_dz_busy", busy, 1'b0);
    send(3'b000, F_MFHI, 32'h0, 32'h0);
    chk("t4_dz_hi", result, 32'd100);
    chk("t4_mfhi_err", err, 1'b0);

    // T5: illegal encodings leave HI/LO untouched; output hold under backpressure
    send(3'b000, 6'b000111, 32'd3, 32'd4);
    chk("t5_ill_result", result, 32'd0);
    chk("t5_ill_err", err, 1'b1);
    send(3'b111, F_ADD, 32'd3, 32'd4);
    chk("t5_ill7_result", result, 32'd0);
    chk("t5_ill7_err", err, 1'b1);
    send(3'b000, F_MFHI, 32'h0, 32'h0);
    chk("t5_hi_kept", result, 32'd100);
    send(3'b000, F_MFLO, 32'h0, 32'h0);
    chk("t5_lo_kept", result, 32'hFFFF_FFFF);
    send(3'b000, F_ADD, 32'd3, 32'd4);
    out_ready = 1'b0;
    in_valid = 1'b1; alu_op = 3'b000; func = F_SUB; a = 32'd1; b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_hold_valid", out_valid, 1'b1);
      chk("t5_hold_result", result, 32'd7);
      chk("t5_hold_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t5_drain_valid", out_valid, 1'b0);
    chk("t5_drain_in_ready", in_ready, 1'b1);

    // T6: reset during MULTU iteration
    send(3'b000, F_MULTU, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    chk("t6_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_result", result, 32'h0);
    chk("t6_rst_zero", zero, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("t6_no_valid", out_valid, 1'b0);
    send(3'b000, F_MFHI, 32'h0, 32'h0);
    chk("t6_hi_cleared", result, 32'h0);
    send(3'b000, F_MFLO, 32'h0, 32'h0);
    chk("t6_lo_cleared", result, 32'h0);
    send(3'b001, 6'b000000, 32'd2, 32'd3);
    chk("t6_add_valid", out_valid, 1'b1);
    chk("t6_add_result", result, 32'd5);
    chk("t6_add_err", err, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
